// File: rtl/avalon_mult_sequencer.sv
// Avalon-MM master that feeds operand pairs to the 4x4 multiplier slave
// (write A, write B, read Z) and returns each product on a valid/ready stream.
module avalon_mult_sequencer #(
    parameter int OPW          = 4,
    parameter int FIFO_DEPTH   = 4,
    parameter int READ_LATENCY = 1
) (
    input  logic             iClk,
    input  logic             iReset_n,
    input  logic             iOpValid,
    output logic             oOpReady,
    input  logic [OPW-1:0]   iOpA,
    input  logic [OPW-1:0]   iOpB,
    output logic             oResValid,
    input  logic             iResReady,
    output logic [2*OPW-1:0] oResult,
    output logic             oResErr,
    output logic [31:0]      oDoneCnt,
    output logic             oBusy,
    output logic             oChipSelect_n,
    output logic             oWrite_n,
    output logic             oRead_n,
    output logic [1:0]       oAddress,
    output logic [31:0]      oWrData,
    input  logic [31:0]      iRdData
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_A,
        S_WR_B,
        S_RD_Z,
        S_WAIT,
        S_RESULT
    } state_t;

    state_t state_q, state_d;

    logic [2*OPW-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             push, pop, fifo_empty;

    logic [OPW-1:0]   a_q, a_d, b_q, b_d;
    logic [CW-1:0]    wait_q, wait_d;
    logic             res_valid_q, res_valid_d;
    logic [2*OPW-1:0] result_q, result_d;
    logic             err_q, err_d;
    logic [31:0]      done_q, done_d;
    logic             cs_n_q, cs_n_d, wr_n_q, wr_n_d, rd_n_q, rd_n_d;
    logic [1:0]       addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;

    assign fifo_empty = (count_q == '0);
    assign oOpReady   = (count_q != (AW+1)'(FIFO_DEPTH));
    assign push       = iOpValid && oOpReady;

    // Entries are stored as {A, B}.
    always_ff @(posedge iClk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {iOpA, iOpB};
        end
    end

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (!push && pop) count_q <= count_q - 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        a_d         = a_q;
        b_d         = b_q;
        wait_d      = wait_q;
        res_valid_d = res_valid_q;
        result_d    = result_q;
        err_d       = err_q;
        done_d      = done_q;
        cs_n_d      = 1'b1;
        wr_n_d      = 1'b1;
        rd_n_d      = 1'b1;
        addr_d      = '0;
        wdata_d     = '0;

        unique case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = S_WR_A;
                end
            end
            S_WR_A: state_d = S_WR_B;
            S_WR_B: state_d = S_RD_Z;
            S_RD_Z: begin
                wait_d  = CW'(READ_LATENCY - 1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (wait_q == '0) begin
                    result_d    = iRdData[2*OPW-1:0];
                    if ((iRdData >> (2*OPW)) != '0) err_d = 1'b1;
                    res_valid_d = 1'b1;
                    state_d     = S_RESULT;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            S_RESULT: begin
                if (iResReady) begin
                    res_valid_d = 1'b0;
                    done_d      = done_q + 32'd1;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = S_WR_A;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (pop) {a_d, b_d} = fifo_mem[rd_ptr_q];

        // Bus registers are loaded from the next state so each command is
        // on the bus for exactly the cycle its state is current.
        unique case (state_d)
            S_WR_A: begin
                cs_n_d  = 1'b0;
                wr_n_d  = 1'b0;
                addr_d  = 2'd0;
                wdata_d = 32'(a_d);
            end
            S_WR_B: begin
                cs_n_d  = 1'b0;
                wr_n_d  = 1'b0;
                addr_d  = 2'd1;
                wdata_d = 32'(b_d);
            end
            S_RD_Z: begin
                cs_n_d = 1'b0;
                rd_n_d = 1'b0;
                addr_d = 2'd2;
            end
            default: ;
        endcase
    end

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            wait_q      <= '0;
            res_valid_q <= 1'b0;
            result_q    <= '0;
            err_q       <= 1'b0;
            done_q      <= '0;
            cs_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
            rd_n_q      <= 1'b1;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            wait_q      <= wait_d;
            res_valid_q <= res_valid_d;
            result_q    <= result_d;
            err_q       <= err_d;
            done_q      <= done_d;
            cs_n_q      <= cs_n_d;
            wr_n_q      <= wr_n_d;
            rd_n_q      <= rd_n_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
        end
    end

    assign oResValid     = res_valid_q;
    assign oResult       = result_q;
    assign oResErr       = err_q;
    assign oDoneCnt      = done_q;
    assign oBusy         = (state_q != S_IDLE) || !fifo_empty;
    assign oChipSelect_n = cs_n_q;
    assign oWrite_n      = wr_n_q;
    assign oRead_n       = rd_n_q;
    assign oAddress      = addr_q;
    assign oWrData       = wdata_q;

endmodule

// File: tb/tb_avalon_mult_sequencer.sv
// Scoreboard bench for avalon_mult_sequencer: behavioural multiplier slave,
// product queue, and a negedge monitor comparing every accepted result.
module tb_avalon_mult_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT 1: READ_LATENCY = 1 ----------------
    logic        op_valid, op_ready, res_valid, res_ready, res_err, busy;
    logic [3:0]  op_a, op_b;
    logic [7:0]  result;
    logic [31:0] done_cnt, wrdata, rddata;
    logic        cs_n, wr_n, rd_n;
    logic [1:0]  addr;

    avalon_mult_sequencer #(.OPW(4), .FIFO_DEPTH(4), .READ_LATENCY(1)) dut (
        .iClk(clk), .iReset_n(rst_n), .iOpValid(op_valid), .oOpReady(op_ready),
        .iOpA(op_a), .iOpB(op_b), .oResValid(res_valid), .iResReady(res_ready),
        .oResult(result), .oResErr(res_err), .oDoneCnt(done_cnt), .oBusy(busy),
        .oChipSelect_n(cs_n), .oWrite_n(wr_n), .oRead_n(rd_n), .oAddress(addr),
        .oWrData(wrdata), .iRdData(rddata)
    );

    // Slave: stores A/B, returns A*B one cycle after the read command.
    logic [31:0] sA, sB, rdpipe;
    logic        err_inject;
    always @(posedge clk) begin
        rdpipe <= $urandom;
        if (!cs_n && !wr_n) begin
            if (addr == 2'd0) sA <= {28'd0, wrdata[3:0]};
            else if (addr == 2'd1) sB <= {28'd0, wrdata[3:0]};
        end
        if (!cs_n && !rd_n)
            rdpipe <= (addr == 2'd2) ? ((sA * sB) | (err_inject ? 32'h100 : 32'h0)) : 32'hDEAD;
    end
    assign rddata = rdpipe;

    // ---------------- DUT 2: READ_LATENCY = 2 ----------------
    logic        op_valid2, op_ready2, res_valid2, res_ready2, res_err2, busy2;
    logic [3:0]  op_a2, op_b2;
    logic [7:0]  result2;
    logic [31:0] done_cnt2, wrdata2, rddata2;
    logic        cs2_n, wr2_n, rd2_n;
    logic [1:0]  addr2;

    avalon_mult_sequencer #(.OPW(4), .FIFO_DEPTH(4), .READ_LATENCY(2)) dut2 (
        .iClk(clk), .iReset_n(rst_n), .iOpValid(op_valid2), .oOpReady(op_ready2),
        .iOpA(op_a2), .iOpB(op_b2), .oResValid(res_valid2), .iResReady(res_ready2),
        .oResult(result2), .oResErr(res_err2), .oDoneCnt(done_cnt2), .oBusy(busy2),
        .oChipSelect_n(cs2_n), .oWrite_n(wr2_n), .oRead_n(rd2_n), .oAddress(addr2),
        .oWrData(wrdata2), .iRdData(rddata2)
    );

    logic [31:0] sA2, sB2, p0, p1;
    always @(posedge clk) begin
        p0 <= $urandom;
        p1 <= p0;
        if (!cs2_n && !wr2_n) begin
            if (addr2 == 2'd0) sA2 <= {28'd0, wrdata2[3:0]};
            else if (addr2 == 2'd1) sB2 <= {28'd0, wrdata2[3:0]};
        end
        if (!cs2_n && !rd2_n) p0 <= (addr2 == 2'd2) ? (sA2 * sB2) : 32'hDEAD;
    end
    assign rddata2 = p1;

    // ---------------- checking ----------------
    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                      name, act, act, exp, exp, cyc);
    endtask

    int unsigned exp_q[$];
    int unsigned wra_log[$], acc_log[$];
    int unsigned acc_cnt = 0, wra_cyc = 0;
    logic        prev_valid = 1'b0, prev_ready = 1'b0, chk_done = 1'b0;
    logic [7:0]  prev_result = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            acc_cnt    = 0;
            prev_valid = 1'b0;
            prev_ready = 1'b0;
            chk_done   = 1'b0;
        end else begin
            if (chk_done) check("done_cnt", done_cnt, acc_cnt);
            chk_done = 1'b0;
            if (op_valid && op_ready) exp_q.push_back(int'(op_a) * int'(op_b));
            if (!wr_n || !rd_n) begin
                check("bus_cs_low", {31'd0, cs_n}, 0);
                check("bus_rw_excl", {31'd0, wr_n | rd_n}, 1);
            end
            if (!rd_n) check("rd_addr", {30'd0, addr}, 2);
            if (!wr_n) check("wr_zero_ext", wrdata >> 4, 0);
            if (!cs_n && !wr_n && addr == 2'd0) begin
                wra_cyc = cyc;
                wra_log.push_back(cyc);
            end
            if (res_valid && !prev_valid) check("pop_to_valid_latency", cyc - wra_cyc, 4);
            if (res_valid && prev_valid && !prev_ready) check("stall_hold", {24'd0, result}, {24'd0, prev_result});
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_result: got %0d, expected no result", result);
                end else begin
                    check("result", {24'd0, result}, exp_q.pop_front());
                end
                acc_cnt++;
                acc_log.push_back(cyc);
                chk_done = 1'b1;
            end
            prev_valid  = res_valid;
            prev_ready  = res_ready;
            prev_result = result;
        end
    end

    // Called just after a posedge; returns just after the accepting posedge.
    task automatic push(input logic [3:0] a, input logic [3:0] b);
        int unsigned n = 0;
        op_a = a;
        op_b = b;
        op_valid = 1'b1;
        @(negedge clk);
        while (!op_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!op_ready) begin
            checks++;
            $display("FAIL push_timeout: got oOpReady=0, expected 1 within 300 cycles");
        end
        @(posedge clk);
        #1 op_valid = 1'b0;
    endtask

    task automatic drain(input int unsigned lim);
        int unsigned n = 0;
        while ((exp_q.size() != 0 || busy) && n < lim) begin
            @(negedge clk);
            n++;
        end
        check("drain_done", {31'd0, exp_q.size() == 0 && !busy}, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_opready"}, {31'd0, op_ready}, 1);
        check({tag, "_resvalid"}, {31'd0, res_valid}, 0);
        check({tag, "_result"}, {24'd0, result}, 0);
        check({tag, "_reserr"}, {31'd0, res_err}, 0);
        check({tag, "_donecnt"}, done_cnt, 0);
        check({tag, "_busy"}, {31'd0, busy}, 0);
        check({tag, "_bus_ctrl"}, {29'd0, cs_n, wr_n, rd_n}, 7);
        check({tag, "_bus_addr"}, {30'd0, addr}, 0);
        check({tag, "_bus_wrdata"}, wrdata, 0);
    endtask

    logic stim_done;

    initial begin
        int unsigned n;
        int          w2, v2;
        rst_n = 1'b1; op_valid = 1'b0; op_a = '0; op_b = '0; res_ready = 1'b1;
        err_inject = 1'b0; stim_done = 1'b0;
        op_valid2 = 1'b0; op_a2 = '0; op_b2 = '0; res_ready2 = 1'b1;
        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 check_reset_outputs("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single op (3,5)
        push(4'd3, 4'd5);
        drain(50);
        check("done_after_first", done_cnt, 1);

        // Back-to-back ops: no IDLE gap between RESULT and next WR_A
        wra_log.delete();
        acc_log.delete();
        push(4'd15, 4'd15);
        push(4'd0, 4'd9);
        drain(50);
        check("b2b_count", wra_log.size(), 2);
        if (wra_log.size() == 2 && acc_log.size() >= 1)
            check("b2b_no_gap", wra_log[1], acc_log[0] + 1);

        // Consumer stall fills the FIFO
        res_ready = 1'b0;
        fork
            begin
                push(4'd3, 4'd5);
                for (int i = 0; i < 5; i++) push(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            end
            begin
                repeat (20) @(negedge clk);
                check("full_opready_low", {31'd0, op_ready}, 0);
                check("stall_valid", {31'd0, res_valid}, 1);
                check("stall_result", {24'd0, result}, 15);
                @(posedge clk);
                #1 res_ready = 1'b1;
            end
        join
        drain(200);

        // Random operands with random consumer back-pressure
        stim_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 24; i++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    push(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
                end
                stim_done = 1'b1;
            end
            begin
                while (!stim_done) begin
                    @(posedge clk);
                    #1 res_ready = 1'($urandom_range(0, 1));
                end
                res_ready = 1'b1;
            end
        join
        drain(400);

        // Slave error bits: sticky
        check("err_initially_clear", {31'd0, res_err}, 0);
        err_inject = 1'b1;
        push(4'd2, 4'd3);
        drain(50);
        check("err_set", {31'd0, res_err}, 1);
        err_inject = 1'b0;
        push(4'd1, 4'd1);
        drain(50);
        check("err_sticky", {31'd0, res_err}, 1);

        // Asynchronous reset during RD_Z
        push(4'd4, 4'd4);
        n = 0;
        while (rd_n && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rdz_reached", {31'd0, rd_n}, 0);
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        push(4'd7, 4'd6);
        drain(50);
        check("done_after_reset", done_cnt, 1);

        // READ_LATENCY=2 instance: (9,4) -> 36, valid 5 cycles after pop
        w2 = -1;
        v2 = -1;
        op_a2 = 4'd9; op_b2 = 4'd4; op_valid2 = 1'b1;
        @(posedge clk);
        #1 op_valid2 = 1'b0;
        n = 0;
        while (v2 < 0 && n < 40) begin
            @(negedge clk);
            if (w2 < 0 && !cs2_n && !wr2_n && addr2 == 2'd0) w2 = int'(cyc);
            if (res_valid2) v2 = int'(cyc);
            n++;
        end
        check("rl2_valid_seen", {31'd0, res_valid2}, 1);
        check("rl2_result", {24'd0, result2}, 36);
        check("rl2_latency", 32'(v2 - w2), 5);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rl2_done", done_cnt2, 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("%0d/%0d checks passed", passed, checks + 1);
        $fatal(1, "watchdog");
    end

endmodule
